// File: rtl/mips_muldiv_if.sv
// Bus between the MIPS controller/datapath and the iterative multiply/divide unit.
// The controller side drives requests and MTHI/MTLO writes; the unit returns status and HI/LO.
interface mips_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             wr_hi;
   logic             wr_lo;
   logic [WIDTH-1:0] wr_data;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, wr_hi, wr_lo, wr_data,
                   input  busy, done, div_zero, hi, lo);
   modport slave  (input  start, op, a, b, wr_hi, wr_lo, wr_data,
                   output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// Define MDU_SIGNED_EN to build signed MULT/DIV; otherwise op[0] is ignored.
module mips_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         reset,
   mips_muldiv_if.slave mdu
);
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               accept;
   logic               is_div;
   logic               b_zero;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opb;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic               div_ok;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] mul_step, div_step;
   logic [WIDTH-1:0]   res_hi, res_lo;
   logic [WIDTH-1:0]   hi_r, lo_r;
   logic               done_r, dz_r;

`ifdef MDU_SIGNED_EN
   logic a_neg, b_neg;
   logic neg_q, neg_r;

   function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] x);
      return x[WIDTH-1] ? -x : x;
   endfunction

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
      return -x;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
      return -x;
   endfunction
`endif

   assign accept = (state == IDLE) && mdu.start;

   // Operand magnitudes; the iteration itself is always unsigned.
   always_comb begin
      a_mag = mdu.a;
      b_mag = mdu.b;
`ifdef MDU_SIGNED_EN
      a_neg = mdu.op[0] & mdu.a[WIDTH-1];
      b_neg = mdu.op[0] & mdu.b[WIDTH-1];
      if (a_neg) a_mag = abs_w(mdu.a);
      if (b_neg) b_mag = abs_w(mdu.b);
`endif
   end

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
      mul_step = {mul_sum, acc[WIDTH-1:1]};
      div_ok   = acc[2*WIDTH-1:WIDTH-1] >= {1'b0, opb};
      div_rem  = acc[2*WIDTH-2:WIDTH-1] - opb;
      div_step = div_ok ? {div_rem, acc[WIDTH-2:0], 1'b1}
                        : {acc[2*WIDTH-2:0], 1'b0};
   end

   always_comb begin
      res_hi = acc[2*WIDTH-1:WIDTH];
      res_lo = acc[WIDTH-1:0];
`ifdef MDU_SIGNED_EN
      if (is_div) begin
         if (neg_q) res_lo = neg_w(res_lo);
         if (neg_r) res_hi = neg_w(res_hi);
      end else if (neg_q) begin
         {res_hi, res_lo} = neg_2w(acc);
      end
`endif
      // Restoring divide by zero already leaves the dividend as remainder.
      if (is_div && b_zero) res_lo = '1;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (mdu.start) state_nxt = RUN;
         RUN:     if (cnt == CNT_W'(WIDTH-1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         acc <= {{WIDTH{1'b0}}, a_mag};
         opb <= b_mag;
      end else if (state == RUN) begin
         acc <= is_div ? div_step : mul_step;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         is_div <= 1'b0;
         b_zero <= 1'b0;
`ifdef MDU_SIGNED_EN
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
`endif
         hi_r   <= '0;
         lo_r   <= '0;
         done_r <= 1'b0;
         dz_r   <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_r <= (state == FIX);
         dz_r   <= (state == FIX) && is_div && b_zero;
         if (accept) begin
            cnt    <= '0;
            is_div <= mdu.op[1];
            b_zero <= (mdu.b == '0);
`ifdef MDU_SIGNED_EN
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
`endif
         end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
         end
         // The result write can never collide with MTHI/MTLO: those act only in IDLE.
         if (state == FIX) begin
            hi_r <= res_hi;
            lo_r <= res_lo;
         end else if (state == IDLE) begin
            if (mdu.wr_hi) hi_r <= mdu.wr_data;
            if (mdu.wr_lo) lo_r <= mdu.wr_data;
         end
      end
   end

   assign mdu.busy     = (state != IDLE);
   assign mdu.done     = done_r;
   assign mdu.div_zero = dz_r;
   assign mdu.hi       = hi_r;
   assign mdu.lo       = lo_r;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: directed corner cases plus random ops against
// an arithmetic reference model; follows MDU_SIGNED_EN the same way the design does.
module tb_mips_muldiv_unit;
   localparam int W = 32;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           t0;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];

   mips_muldiv_if #(.WIDTH(W)) dif ();
   mips_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .mdu(dif));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t        r;
      logic        sgn;
      logic [63:0] p;
      longint      sa, sbv, q, rm;
      sgn = 1'b0;
`ifdef MDU_SIGNED_EN
      sgn = op[0];
`endif
      r.dz = 1'b0;
      r.t0 = 0;
      if (!op[1]) begin
         if (sgn) p = longint'(signed'(a)) * longint'(signed'(b));
         else     p = {32'b0, a} * {32'b0, b};
         r.hi = p[63:32];
         r.lo = p[31:0];
      end else if (b == 0) begin
         r.dz = 1'b1;
         r.hi = a;
         r.lo = '1;
      end else if (sgn) begin
         sa   = longint'(signed'(a));
         sbv  = longint'(signed'(b));
         q    = sa / sbv;
         rm   = sa % sbv;
         r.lo = q[31:0];
         r.hi = rm[31:0];
      end else begin
         r.lo = a / b;
         r.hi = a % b;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] rand_w();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 32'd1;
         2:       return '1;
         3:       return 32'h8000_0000;
         4:       return 32'h7fff_ffff;
         5:       return W'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (dif.busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (dif.busy) check("idle_timeout", 1, 0);
   endtask

   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic whi, input logic wlo, input logic [W-1:0] wdata);
      exp_t e;
      wait_idle();
      dif.start = 1'b1; dif.op = op; dif.a = a; dif.b = b;
      dif.wr_hi = whi;  dif.wr_lo = wlo; dif.wr_data = wdata;
      @(posedge clk);
      #1;
      dif.start = 1'b0; dif.wr_hi = 1'b0; dif.wr_lo = 1'b0;
      e    = model(op, a, b);
      e.t0 = cyc;
      sb.push_back(e);
   endtask

   // Monitor: every done pops one expected result; busy must cover the whole operation.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (dif.done) begin
            if (sb.size() == 0) begin
               check("spurious_done", 1, 0);
            end else begin
               e = sb.pop_front();
               check("hi", dif.hi, e.hi);
               check("lo", dif.lo, e.lo);
               check("div_zero", dif.div_zero, e.dz);
               check("latency", cyc - e.t0, W + 1);
               check("busy_at_done", dif.busy, 0);
            end
         end else if (sb.size() != 0) begin
            check("busy_inflight", dif.busy, 1);
         end
      end
   end

   initial begin
      int n, dones;
      reset = 1'b1;
      dif.start = 1'b0; dif.op = 2'b00; dif.a = '0; dif.b = '0;
      dif.wr_hi = 1'b0; dif.wr_lo = 1'b0; dif.wr_data = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", dif.busy, 0);
      check("rst_done", dif.done, 0);
      check("rst_div_zero", dif.div_zero, 0);
      check("rst_hi", dif.hi, 0);
      check("rst_lo", dif.lo, 0);
      reset = 1'b0;

      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
      issue(2'b01, -32'sd7, 32'd3, 0, 0, 0);
      issue(2'b11, -32'sd7, 32'd2, 0, 0, 0);
      issue(2'b10, 32'd100, 32'd0, 0, 0, 0);
      issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
      issue(2'b11, 32'hFFFF_FFF0, 32'd0, 0, 0, 0);
      issue(2'b01, 32'hFFFF_FFFF, 32'd2, 0, 0, 0);

      // MTHI/MTLO in IDLE, together and singly
      wait_idle();
      dif.wr_hi = 1'b1; dif.wr_lo = 1'b1; dif.wr_data = 32'hAAAA_AAAA;
      @(negedge clk);
      dif.wr_hi = 1'b0; dif.wr_lo = 1'b0;
      check("mt_both_hi", dif.hi, 32'hAAAA_AAAA);
      check("mt_both_lo", dif.lo, 32'hAAAA_AAAA);
      dif.wr_lo = 1'b1; dif.wr_data = 32'h5555_5555;
      @(negedge clk);
      dif.wr_lo = 1'b0;
      check("mtlo_hi_kept", dif.hi, 32'hAAAA_AAAA);
      check("mtlo_lo", dif.lo, 32'h5555_5555);

      // MTHI and a second start while busy are both ignored
      issue(2'b00, 32'd3, 32'd5, 0, 0, 0);
      repeat (3) @(negedge clk);
      dif.wr_hi = 1'b1; dif.wr_data = 32'h1234;
      dif.start = 1'b1; dif.op = 2'b10; dif.a = 32'd50; dif.b = 32'd7;
      @(negedge clk);
      dif.wr_hi = 1'b0; dif.start = 1'b0;
      check("mthi_busy_ignored", dif.hi, 32'hAAAA_AAAA);
      wait_idle();
      dif.wr_hi = 1'b1; dif.wr_data = 32'h1234;
      @(negedge clk);
      dif.wr_hi = 1'b0;
      check("mthi_idle", dif.hi, 32'h1234);

      // start and MTHI/MTLO in the same IDLE cycle: write lands now, result later
      issue(2'b00, 32'd2, 32'd3, 1, 1, 32'hDEAD_BEEF);
      @(negedge clk);
      check("mt_with_start_hi", dif.hi, 32'hDEAD_BEEF);
      check("mt_with_start_lo", dif.lo, 32'hDEAD_BEEF);

      // Reset in the middle of an operation discards it
      issue(2'b11, 32'h1234_5678, 32'd9, 0, 0, 0);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      sb.delete();
      #1;
      check("midrst_busy", dif.busy, 0);
      check("midrst_done", dif.done, 0);
      check("midrst_hi", dif.hi, 0);
      check("midrst_lo", dif.lo, 0);
      @(negedge clk);
      reset = 1'b0;
      dones = 0;
      repeat (W + 6) begin
         @(negedge clk);
         if (dif.done) dones++;
      end
      check("no_done_after_reset", dones, 0);
      check("idle_after_reset", dif.busy, 0);

      for (int i = 0; i < 60; i++) begin
         issue(2'($urandom_range(0, 3)), rand_w(), rand_w(), 0, 0, 0);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
      end

      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
